load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Memory stage directly downstream of the ALU. Takes the ALU result as the effective address
//   and rs2 as store data, then runs one data-bus transaction per load/store over a req/ack handshake.
//   Returns sign/zero-extended load data to writeback. Asserts stall so the core holds PC until the access retires.
// PARAMETERS
//   TIMEOUT  16  cycles in BUSY before abort (used only with LSU_TIMEOUT_EN); min 2, max 255
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   mem_rd     in   1   load instruction in flight (held by core while stall=1)
//   mem_wr     in   1   store instruction in flight (held by core while stall=1)
//   funct3     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
//   addr       in   32  effective address (ALU OUT)
//   wdata      in   32  store data (rs2)
//   rdata      out  32  extended load data; valid in DONE
//   stall      out  1   hold PC/pipeline
//   misalign   out  1   misaligned-access pulse
//   bus_err    out  1   timeout abort pulse (constant 0 without LSU_TIMEOUT_EN)
//   bus_req    out  1   transaction request
//   bus_we     out  1   1=write
//   bus_addr   out  32  {addr[31:2],2'b00}
//   bus_be     out  4   byte enables
//   bus_wdata  out  32  store data replicated into lanes
//   bus_rdata  in   32  read data, valid with bus_ack
//   bus_ack    in   1   one-cycle completion strobe
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; all outputs 0, including bus_req, which drops mid-transaction.
//   FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE:
//     - access = mem_rd|mem_wr. If both are set, treat as store.
//     - Alignment: misaligned if H/HU with addr[0]=1, or W with addr[1:0]!=0.
//     - Misaligned: misalign=1 combinationally; stall=0; no bus activity; rdata=0; stay IDLE.
//     - Aligned: stall=1 combinationally; on clk, register bus_addr/be/wdata/we and funct3/addr[1:0]; go BUSY.
//   BUSY:
//     - bus_req=1, stall=1; address/data/be stable until ack.
//     - On bus_ack: register rdata, go DONE. Ack outside BUSY is ignored.
//   DONE (exactly 1 cycle):
//     - stall=0, so the instruction retires.
//     - rdata valid for loads, 0 for stores; held until the next access leaves IDLE.
//     - Requests are ignored here; the retiring instruction is still presented. Then go IDLE.
//   Latency: aligned access with ack N cycles after entry to BUSY (N>=0) gives stall high for N+2 cycles.
//   Byte lanes, o = addr[1:0]:
//     - B: be = 1<<o, wdata = {4{wdata[7:0]}}
//     - H: be = 0011 or 1100, wdata = {2{wdata[15:0]}}
//     - W: be = 1111
//   Load extract: select the lane by o. B/H sign-extend bit 7/15; BU/HU zero-extend.
//   Unsupported funct3 (011,110,111): handled as W.
// CONFIGURATION
//   LSU_TIMEOUT_EN defined:
//     - 8-bit counter cleared on entry to BUSY, incremented each BUSY cycle.
//     - When it reaches TIMEOUT-1 without ack: drop bus_req, set rdata=0, pulse bus_err in DONE, go DONE.
//     - If ack arrives in the same cycle as expiry, the ack wins.
//   LSU_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; bus_err tied 0.
// TESTING
//   - LW addr=0x100, bus_rdata=0xDEADBEEF, ack 3 cycles after req: rdata=0xDEADBEEF; stall high 5 cycles; bus_addr=0x100.
//   - LB addr=0x103, rdata=0x80xxxxxx: rdata=0xFFFFFF80. LBU same: 0x00000080. LHU addr=0x102, rdata=0xABCDxxxx: 0x0000ABCD.
//   - SB addr=0x201, wdata=0x12345678: bus_we=1, be=0010, bus_wdata=0x78787878, bus_addr=0x200. SH addr=0x202: be=1100, wdata=0x56785678.
//   - LW addr=0x102: misalign=1, stall=0, bus_req never asserted. SH addr=0x5: same.
//   - rst_n low while BUSY: bus_req/stall drop without clock. After release with mem_rd held, a fresh transaction starts.
//   - LSU_TIMEOUT_EN, TIMEOUT=16, no ack: bus_req falls after 16 BUSY cycles; bus_err=1 and rdata=0 for one cycle. Ack on cycle 16: normal data, bus_err=0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage behind the ALU. Each aligned load or store
// runs one req/ack transaction on the data bus. The unit holds the core with
// stall until the access retires, and returns extended load data to writeback.
// A misaligned access is flagged immediately and never reaches the bus.
// Optional feature: define LSU_TIMEOUT_EN to abort a transaction that gets no
// ack within TIMEOUT busy cycles. The abort is reported on bus_err_o.

module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Last busy-cycle count before the transaction is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e state_q, state_d;

    // Request decode. The size comes from funct3[1:0]. The unsigned forms
    // share a size with their signed forms, and 011/110/111 fall into word.
    logic access, is_byte, is_half, is_word, misaligned, start;

    assign access     = mem_rd_i | mem_wr_i;
    assign is_byte    = (funct3_i[1:0] == 2'b00);
    assign is_half    = (funct3_i[1:0] == 2'b01);
    assign is_word    = ~is_byte & ~is_half;
    assign misaligned = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
    assign start      = access & ~misaligned;

    // Transaction registers, captured when an access leaves IDLE.
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;

    // Abort condition. This stays tied low when the timeout is not built.
    logic expire;

    // Byte-lane steering for stores: replicate the datum into every lane it may occupy.
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
        if (is_byte) begin
            be_d    = 4'b0001 << addr_i[1:0];
            wdata_d = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata_i[15:0]}};
        end
    end

    // Load extraction: pick the lane by the captured offset, then extend it.
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = bus_rdata_i[7:0];
            2'd1:    byte_sel = bus_rdata_i[15:8];
            2'd2:    byte_sel = bus_rdata_i[23:16];
            default: byte_sel = bus_rdata_i[31:24];
        endcase
        half_sel = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = bus_rdata_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic. DONE always lasts one cycle, so the retiring
    // instruction cannot start a second transaction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_BUSY;
            S_BUSY:  if (bus_ack_i || expire) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the bus request on entry to BUSY, and the load result on ack.
    // rdata is cleared at launch, so a store or an abort retires with zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            we_q    <= mem_wr_i;
            addr_q  <= {addr_i[31:2], 2'b00};
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= funct3_i;
            off_q   <= addr_i[1:0];
            rdata_q <= '0;
        end else if (state_q == S_BUSY && bus_ack_i) begin
            rdata_q <= we_q ? 32'd0 : load_ext;
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;

    assign expire = (state_q == S_BUSY) && (cnt_q == TO_LAST);

    // Busy-cycle counter. It is zero on entry to BUSY. An ack that arrives
    // in the expiry cycle wins, so no error is raised for it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_BUSY) cnt_q <= cnt_q + 8'd1;
            else                   cnt_q <= '0;
            err_q <= expire & ~bus_ack_i;
        end
    end

    assign bus_err_o = err_q;
`else
    // Without the timeout, BUSY waits for ack indefinitely.
    logic unused_timeout;
    assign unused_timeout = ^TO_LAST;
    assign expire         = 1'b0;
    assign bus_err_o      = 1'b0;
`endif

    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;

    // Outputs that depend on state. Reset forces them low at once, even
    // while the core is still presenting a request.
    always_comb begin
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        bus_req_o  = 1'b0;
        rdata_o    = rdata_q;
        case (state_q)
            S_IDLE: begin
                stall_o    = start;
                misalign_o = access & misaligned;
                if (access & misaligned) rdata_o = '0;
            end
            S_BUSY: begin
                stall_o   = 1'b1;
                bus_req_o = 1'b1;
            end
            default: ;
        endcase
        if (!rst_ni) begin
            stall_o    = 1'b0;
            misalign_o = 1'b0;
            bus_req_o  = 1'b0;
            rdata_o    = '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit. Directed accesses are checked every cycle
// against a transaction-level model. Literal expectations pin the key results.
module tb_load_store_unit;

    localparam int TO = 16;
`ifdef LSU_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd = 1'b0, mem_wr = 1'b0, bus_ack = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        stall, misalign, bus_err, bus_req, bus_we;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
        .stall_o(stall), .misalign_o(misalign), .bus_err_o(bus_err),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_be_o(bus_be), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
        .bus_ack_i(bus_ack)
    );

    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    logic        exp_stall = 0, exp_req = 0, exp_mis = 0, exp_err = 0, exp_we = 0;
    logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_be = '0;
    logic [31:0] held = '0;

    int stall_seen = 0, req_cycles = 0, err_cycles = 0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_be = '0;
    logic        cap_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int s = m_size(f3);
        if (s == 4) return 4'hF;
        return 4'((s == 1 ? 1 : 3) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int s = m_size(f3);
        if (s == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (s == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (a % 4));
        int s = m_size(f3);
        if (s == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (s == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, exp_stall});
            chk("bus_req", {31'd0, bus_req}, {31'd0, exp_req});
            chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
            chk("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
            chk("rdata", rdata, exp_rdata);
            if (exp_req) begin
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
                chk("bus_wdata", bus_wdata, exp_wdata);
                chk("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
            end
        end
    end

    always @(negedge clk) begin
        if (stall === 1'b1) stall_seen++;
        if (bus_err === 1'b1) err_cycles++;
        if (bus_req === 1'b1) begin
            req_cycles++;
            cap_addr  = bus_addr;
            cap_be    = bus_be;
            cap_wdata = bus_wdata;
            cap_we    = bus_we;
        end
    end

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        exp_stall = 0; exp_req = 0; exp_mis = 0; exp_err = 0; exp_rdata = held;
    endtask

    // One access. The ack comes in BUSY cycle n (0 = first BUSY cycle).
    // n < 0 means no ack.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] brd, input int n,
                          output logic [31:0] got, output int stalls);
        bit tout;
        int busy;
        mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
        bus_ack = 0; bus_rdata = brd;
        stall_seen = 0;
        got = '0;
        if (m_mis(f3, a)) begin
            exp_stall = 0; exp_req = 0; exp_mis = 1; exp_err = 0; exp_rdata = '0;
            step();
            mem_rd = 0; mem_wr = 0; set_idle();
            step();
        end else begin
            exp_stall = 1; exp_req = 0; exp_mis = 0; exp_err = 0; exp_rdata = held;
            step();
            tout = (n < 0) || (TO_ON && n >= TO);
            busy = tout ? TO : n + 1;
            held = '0;
            exp_req = 1; exp_rdata = '0; exp_addr = a & ~32'd3;
            exp_be = m_be(f3, a); exp_wdata = m_wdata(f3, wd); exp_we = wr;
            for (int i = 0; i < busy; i++) begin
                bus_ack = (i == n);
                step();
            end
            // Stray ack while retiring must not disturb anything.
            bus_ack = 1; bus_rdata = ~brd;
            held = (tout || wr) ? 32'd0 : m_load(f3, a, brd);
            exp_stall = 0; exp_req = 0; exp_err = tout; exp_rdata = held;
            @(negedge clk);
            got = rdata;
            @(posedge clk);
            #1;
            bus_ack = 0; mem_rd = 0; mem_wr = 0; set_idle();
            step();
        end
        stalls = stall_seen;
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [31:0] got;
        int st, rq0;

        // Reset state, including a request presented during reset.
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        mem_rd = 1; #1;
        chk("rst_stall_req", {31'd0, stall}, 32'd0);
        mem_rd = 0;
        @(posedge clk); #1;
        rst_n = 1;
        set_idle();
        chk_en = 1;
        step();

        access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, got, st);
        chk("lw_data", got, 32'hDEADBEEF);
        chk("lw_stall_cycles", st, 5);
        chk("lw_addr", cap_addr, 32'h100);

        access(1, 0, 3'b000, 32'h103, 0, 32'h8012_3456, 0, got, st);
        chk("lb_data", got, 32'hFFFFFF80);
        chk("lb_stall_cycles", st, 2);
        access(1, 0, 3'b100, 32'h103, 0, 32'h8012_3456, 1, got, st);
        chk("lbu_data", got, 32'h00000080);
        access(1, 0, 3'b101, 32'h102, 0, 32'hABCD_1234, 2, got, st);
        chk("lhu_data", got, 32'h0000ABCD);
        access(1, 0, 3'b001, 32'h102, 0, 32'hABCD_1234, 0, got, st);
        chk("lh_data", got, 32'hFFFFABCD);
        access(1, 0, 3'b000, 32'h101, 0, 32'h0000_7F00, 0, got, st);
        chk("lb_pos_data", got, 32'h0000007F);

        access(0, 1, 3'b000, 32'h201, 32'h12345678, 0, 1, got, st);
        chk("sb_we", {31'd0, cap_we}, 32'd1);
        chk("sb_be", {28'd0, cap_be}, 32'h2);
        chk("sb_wdata", cap_wdata, 32'h78787878);
        chk("sb_addr", cap_addr, 32'h200);
        chk("sb_rdata", got, 32'd0);
        access(0, 1, 3'b001, 32'h202, 32'h12345678, 0, 0, got, st);
        chk("sh_be", {28'd0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'h56785678);
        // Both strobes set: handled as a store.
        access(1, 1, 3'b010, 32'h204, 32'hA5A5_0F0F, 32'h1111_1111, 2, got, st);
        chk("both_we", {31'd0, cap_we}, 32'd1);
        chk("both_rdata", got, 32'd0);

        // Misaligned accesses never reach the bus.
        rq0 = req_cycles;
        access(1, 0, 3'b010, 32'h102, 0, 0, 0, got, st);
        chk("lw_mis_stall", st, 0);
        access(0, 1, 3'b001, 32'h5, 32'hFFFF, 0, 0, got, st);
        access(1, 0, 3'b011, 32'h111, 0, 0, 0, got, st);
        chk("mis_no_req", req_cycles - rq0, 0);

        // Unsupported funct3 behaves as a word access.
        access(1, 0, 3'b110, 32'h110, 0, 32'h0BAD_F00D, 1, got, st);
        chk("f3_110_data", got, 32'h0BADF00D);

        // Ack while idle is ignored.
        bus_ack = 1; bus_rdata = 32'h5555_AAAA; set_idle();
        step();
        bus_ack = 0;
        step();

        // Reset while BUSY drops the request at once, without a clock.
        mem_rd = 1; funct3 = 3'b010; addr = 32'h300; wdata = 32'h7;
        exp_stall = 1; exp_req = 0; exp_mis = 0; exp_err = 0; exp_rdata = held;
        step();
        held = '0;
        exp_req = 1; exp_rdata = '0; exp_addr = 32'h300; exp_be = 4'hF;
        exp_wdata = m_wdata(3'b010, 32'h7); exp_we = 0;
        step();
        chk_en = 0;
        #2;
        chk("busy_before_rst", {31'd0, bus_req}, 32'd1);
        rst_n = 0;
        #1;
        chk("rst_async_req", {31'd0, bus_req}, 32'd0);
        chk("rst_async_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        held = '0;
        set_idle();
        chk_en = 1;
        access(1, 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 1, got, st);
        chk("post_rst_data", got, 32'hCAFEF00D);
        chk("post_rst_stall", st, 3);

`ifdef LSU_TIMEOUT_EN
        rq0 = req_cycles;
        access(1, 0, 3'b010, 32'h400, 0, 32'h1111_1111, -1, got, st);
        chk("to_rdata", got, 32'd0);
        chk("to_req_cycles", req_cycles - rq0, 16);
        chk("to_err_cycles", err_cycles, 1);
        access(1, 0, 3'b010, 32'h404, 0, 32'h2222_2222, 15, got, st);
        chk("to_ack_wins", got, 32'h22222222);
        chk("to_ack_err", err_cycles, 1);
`else
        chk("no_err_ever", err_cycles, 0);
`endif

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
